// File: rtl/stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: pause vector codes,
// FSM state encodings and counter reset value.
package stall_ctrl_pkg;

  localparam int PAUSE_LENGTH = 2;

  // bit1 = rt, bit0 = rs
  localparam logic [PAUSE_LENGTH-1:0] PAUSE_NO   = 2'b00;
  localparam logic [PAUSE_LENGTH-1:0] PAUSE_RS   = 2'b01;
  localparam logic [PAUSE_LENGTH-1:0] PAUSE_RT   = 2'b10;
  localparam logic [PAUSE_LENGTH-1:0] PAUSE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [31:0] INIT_32 = 32'd0;

endpackage

// File: rtl/stall_perf_counter.sv
// Stall statistics: saturating consecutive-stall length, wrapping total
// stall count and a sticky over-long-stall flag, all advanced by en.
module stall_perf_counter
  import stall_ctrl_pkg::*;
#(
  parameter int PERF_W    = 32,
  parameter int MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [1:0]        stall_cnt,
  output logic [PERF_W-1:0] stall_total,
  output logic              stall_err
);

  localparam logic [1:0] CNT_SAT = 2'd3;
  localparam logic [1:0] CNT_MAX = 2'(MAX_STALL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt   <= 2'd0;
      stall_total <= PERF_W'(INIT_32);
      stall_err   <= 1'b0;
    end else if (en) begin
      if (stall_cnt != CNT_SAT) begin
        stall_cnt <= stall_cnt + 2'd1;
      end
      stall_total <= stall_total + PERF_W'(1);
      // a stall edge arriving with the count already at the bound is one too many
      if (stall_cnt == CNT_MAX) begin
        stall_err <= 1'b1;
      end
    end else begin
      stall_cnt <= 2'd0;
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: freezes PC and IF/ID on a decode hazard,
// bubbles ID/EX, flushes on taken branch and reports stall statistics.
//
// state    | meaning
// ST_RUN   | normal issue
// ST_STALL | hazard hold in progress
// ST_FLUSH | wrong-path instruction discarded this cycle
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 3,
  parameter int PERF_W    = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PAUSE_LENGTH-1:0] pause,
  input  logic                    id_valid,
  input  logic                    id_reg_we,
  input  logic [ADDR_W-1:0]       id_dest_addr,
  input  logic                    ex_branch_taken,
  output logic                    pc_hold,
  output logic                    ifid_hold,
  output logic                    ifid_flush,
  output logic                    idex_bubble,
  output logic [ADDR_W-1:0]       collision_addr,
  output logic [1:0]              stall_cnt,
  output logic [PERF_W-1:0]       stall_total,
  output logic                    stall_err
);

  state_t state, state_nxt;
  logic   stall_req;
  logic   flush;
  logic   cnt_en;

  assign stall_req = id_valid & (pause != PAUSE_NO);
  assign flush     = ex_branch_taken;
  assign cnt_en    = stall_req & ~flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_RUN;
    case (state)
      ST_RUN, ST_STALL: begin
        if (flush) begin
          state_nxt = ST_FLUSH;
        end else if (cnt_en) begin
          state_nxt = ST_STALL;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      // a flush never hands over directly to a stall; RUN re-evaluates first
      ST_FLUSH: state_nxt = flush ? ST_FLUSH : ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Outputs follow the inputs in the same cycle because pause is combinational.
  always_comb begin
    pc_hold        = 1'b0;
    ifid_hold      = 1'b0;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    collision_addr = '0;
    if (!rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall_req) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else if (id_valid && id_reg_we) begin
      collision_addr = id_dest_addr;
    end
  end

  stall_perf_counter #(
    .PERF_W    (PERF_W),
    .MAX_STALL (MAX_STALL)
  ) u_perf (
    .clk         (clk),
    .rst         (rst),
    .en          (cnt_en),
    .stall_cnt   (stall_cnt),
    .stall_total (stall_total),
    .stall_err   (stall_err)
  );

endmodule
